// File: rtl/dotp_pkg.sv
// rtl/dotp_pkg.sv - shared sizing helpers for the dot-product pipeline
// ACCUM_EN mirrors the DOTP_ACCUM_EN build macro so widths agree everywhere.
package dotp_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  function automatic int out_w(input int width, input int lanes, input int guard);
    return 2 * width + clog2(lanes) + guard;
  endfunction

  function automatic int tree_stages(input int lanes);
    return clog2(lanes);
  endfunction

  function automatic int latency(input int lanes);
    return 2 + clog2(lanes);
  endfunction

`ifdef DOTP_ACCUM_EN
  localparam bit ACCUM_EN = 1'b1;
`else
  localparam bit ACCUM_EN = 1'b0;
`endif

  localparam int DEF_LANES   = 4;
  localparam int DEF_STAGES  = tree_stages(DEF_LANES);
  localparam int DEF_LATENCY = latency(DEF_LANES);

endpackage

// File: rtl/dotp_adder_tree.sv
// rtl/dotp_adder_tree.sv - registered binary adder tree, one register per level
// All nodes are kept at the final width; a single lane collapses to a wire.
module dotp_adder_tree
  import dotp_pkg::*;
#(
  parameter int N      = 4,
  parameter int IN_W   = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic [N*IN_W-1:0]            in_data,
  output logic                         out_valid,
  output logic [IN_W+clog2(N)-1:0]     out_data
);

  localparam int K     = clog2(N);
  localparam int OUT_W = IN_W + K;

  if (K == 0) begin : g_wire
    logic unused_k0;
    assign unused_k0 = ^{clk, rst, en};
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_tree
    // Node storage: leaves at the bottom, then each level packed above it.
    function automatic int off(input int l);
      return (2 * N - 2 * (N >> l)) * OUT_W;
    endfunction

    logic [N*OUT_W-1:0]       leaf;
    logic [(N-1)*OUT_W-1:0]   sums;
    logic [(2*N-1)*OUT_W-1:0] all_nodes;
    logic [K-1:0]             vld_r;

    always_comb begin
      leaf = '0;
      for (int i = 0; i < N; i++) begin
        leaf[i*OUT_W +: OUT_W] = {{K{SIGNED & in_data[i*IN_W+IN_W-1]}},
                                  in_data[i*IN_W +: IN_W]};
      end
    end

    assign all_nodes = {sums, leaf};

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_r <= '0;
        sums  <= '0;
      end else if (en) begin
        vld_r[0] <= in_valid;
        for (int l = 1; l < K; l++) begin
          vld_r[l] <= vld_r[l-1];
        end
        for (int l = 1; l <= K; l++) begin
          for (int i = 0; i < (N >> l); i++) begin
            sums[off(l) - N*OUT_W + i*OUT_W +: OUT_W] <=
              all_nodes[off(l-1) + (2*i)*OUT_W +: OUT_W] +
              all_nodes[off(l-1) + (2*i+1)*OUT_W +: OUT_W];
          end
        end
      end
    end

    assign out_valid = vld_r[K-1];
    assign out_data  = all_nodes[off(K) +: OUT_W];
  end

endmodule

// File: rtl/dot_product_pipe.sv
// rtl/dot_product_pipe.sv - pipelined LANES-wide dot product with valid/ready flow
// Define DOTP_ACCUM_EN to accumulate multi-beat vectors up to in_last.
module dot_product_pipe
  import dotp_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int LANES     = 4,
  parameter bit SIGNED    = 1'b0,
  parameter int ACC_GUARD = 8,
  localparam int OUT_W    = out_w(WIDTH, LANES, ACCUM_EN ? ACC_GUARD : 0)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data
);

  localparam int PW = 2 * WIDTH;
  localparam int K  = clog2(LANES);
  localparam int TW = PW + K;

  // One global enable; in_ready is combinational on out_ready by design.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  function automatic logic [PW-1:0] mul(input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y);
    logic [PW-1:0] xe;
    logic [PW-1:0] ye;
    xe = {{WIDTH{SIGNED & x[WIDTH-1]}}, x};
    ye = {{WIDTH{SIGNED & y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  logic [LANES*PW-1:0] prod;
  logic                prod_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod   <= '0;
      prod_v <= 1'b0;
    end else if (adv) begin
      prod_v <= in_valid;
      for (int i = 0; i < LANES; i++) begin
        prod[i*PW +: PW] <= mul(a[i*WIDTH +: WIDTH], b[i*WIDTH +: WIDTH]);
      end
    end
  end

  logic          tree_v;
  logic [TW-1:0] tree_sum;

  dotp_adder_tree #(
    .N      (LANES),
    .IN_W   (PW),
    .SIGNED (SIGNED)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .en        (adv),
    .in_valid  (prod_v),
    .in_data   (prod),
    .out_valid (tree_v),
    .out_data  (tree_sum)
  );

  logic [OUT_W-1:0] tree_ext;
  if (OUT_W > TW) begin : g_ext
    assign tree_ext = {{(OUT_W-TW){SIGNED & tree_sum[TW-1]}}, tree_sum};
  end else begin : g_noext
    assign tree_ext = tree_sum;
  end

`ifdef DOTP_ACCUM_EN
  // in_last rides alongside the data so it meets the tree sum at stage O.
  logic [K:0]       last_pipe;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_next;
  logic             first;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pipe <= '0;
    end else if (adv) begin
      last_pipe[0] <= in_last;
      for (int l = 1; l <= K; l++) begin
        last_pipe[l] <= last_pipe[l-1];
      end
    end
  end

  assign acc_next = (first ? '0 : acc) + tree_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= tree_v && last_pipe[K];
      if (tree_v) begin
        acc   <= acc_next;
        first <= last_pipe[K];
        if (last_pipe[K]) out_data <= acc_next;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = in_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= tree_v;
      if (tree_v) out_data <= tree_ext;
    end
  end
`endif

endmodule

// File: tb/tb_dot_product_pipe.sv
// tb/tb_dot_product_pipe.sv - scoreboard bench driving unsigned and signed instances in lockstep
module tb_dot_product_pipe;
  import dotp_pkg::*;

  localparam int WIDTH = 16;
  localparam int LANES = 4;
  localparam int GUARD = 8;
  localparam int OW    = out_w(WIDTH, LANES, ACCUM_EN ? GUARD : 0);
  localparam int LAT   = latency(LANES);

  typedef struct {
    logic [OW-1:0] data;
    int            acc_cyc;
    bit            chk_lat;
  } exp_t;

  exp_t sb [2][$];

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_last = 1'b0;
  logic                   out_ready = 1'b1;
  logic [LANES*WIDTH-1:0] a = '0;
  logic [LANES*WIDTH-1:0] b = '0;
  logic [1:0]             in_ready_w;
  logic [1:0]             out_valid_w;
  logic [OW-1:0]          out_data_w [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit presented [2];
  bit mon_en = 1'b0;
  bit pat_en = 1'b0;
  int pat_idx = 0;
  bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  dot_product_pipe #(.WIDTH(WIDTH), .LANES(LANES), .SIGNED(1'b0), .ACC_GUARD(GUARD)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_last(in_last),
    .a(a), .b(b), .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0])
  );

  dot_product_pipe #(.WIDTH(WIDTH), .LANES(LANES), .SIGNED(1'b1), .ACC_GUARD(GUARD)) s_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_last(in_last),
    .a(a), .b(b), .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] pack(input logic [15:0] w3, input logic [15:0] w2,
                                       input logic [15:0] w1, input logic [15:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [OW-1:0] sx(input longint v);
    return OW'(v);
  endfunction

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // out_ready follows the stall pattern only while pat_en is set.
  always @(posedge clk) begin
    #1;
    out_ready = pat_en ? pat[pat_idx] : 1'b1;
    if (pat_en) pat_idx = (pat_idx + 1) % 5;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < 2; p++) begin
        check("in_ready_eq_adv", OW'(in_ready_w[p]), OW'(!out_valid_w[p] || out_ready));
        if (out_valid_w[p]) begin
          if (sb[p].size() == 0) begin
            check("unexpected_out_valid", OW'(out_valid_w[p]), '0);
          end else begin
            check(p == 0 ? "u_out_data" : "s_out_data", out_data_w[p], sb[p][0].data);
            if (!presented[p] && sb[p][0].chk_lat)
              check("latency", OW'(cyc - sb[p][0].acc_cyc), OW'(LAT));
            presented[p] = 1'b1;
            if (out_ready) begin
              void'(sb[p].pop_front());
              presented[p] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the accept edge.
  task automatic send(input logic [63:0] av, input logic [63:0] bv, input bit last,
                      input bit push, input longint eu, input longint es, input bit lat);
    bit done;
    done = 1'b0;
    a = av;
    b = bv;
    in_last = last;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready_w[0]) begin
        if (push) begin
          sb[0].push_back('{sx(eu), cyc, lat});
          sb[1].push_back('{sx(es), cyc, lat});
        end
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) fail_now("in_ready_timeout");
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && (sb[0].size() != 0 || sb[1].size() != 0); t++) begin
      @(posedge clk);
      #1;
    end
    if (sb[0].size() != 0 || sb[1].size() != 0) fail_now("drain_timeout");
  endtask

  task automatic pulse_reset_and_check();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < LAT + 2; t++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        check("post_rst_out_valid", OW'(out_valid_w[p]), '0);
        check("post_rst_out_data", out_data_w[p], '0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      check("rst_out_valid", OW'(out_valid_w[p]), '0);
      check("rst_out_data", out_data_w[p], '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 2; p++) check("rst_in_ready", OW'(in_ready_w[p]), OW'(1));
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    send(pack(16'd4, 16'd3, 16'd2, 16'd1), pack(16'd8, 16'd7, 16'd6, 16'd5), 1'b1, 1'b1, 70, 70, 1'b1);
    drain();
    send(pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
         1'b1, 1'b1, 64'h3_FFF8_0004, 4, 1'b1);
    send(pack(16'd4, 16'd3, 16'hFFFE, 16'hFFFF), pack(16'd8, 16'hFFF9, 16'd6, 16'd5),
         1'b1, 1'b1, 917498, -6, 1'b1);
    send(pack(16'h8000, 16'h8000, 16'h8000, 16'h8000), pack(16'h8000, 16'h8000, 16'h8000, 16'h8000),
         1'b1, 1'b1, 64'h1_0000_0000, 64'h1_0000_0000, 1'b1);
    send(pack(16'h8000, 16'd0, 16'd0, 16'd0), pack(16'd2, 16'd0, 16'd0, 16'd0),
         1'b1, 1'b1, 65536, -65536, 1'b1);
    send(pack(16'd0, 16'd0, 16'd0, 16'd0), pack(16'd0, 16'd0, 16'd0, 16'd0), 1'b1, 1'b1, 0, 0, 1'b1);
    drain();

    pat_idx = 0;
    pat_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(pack(16'(k), 16'(k), 16'(k), 16'(k)), pack(16'd4, 16'd3, 16'd2, 16'd1),
           1'b1, 1'b1, 10 * k, 10 * k, 1'b0);
    end
    drain();
    pat_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifdef DOTP_ACCUM_EN
    send(pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd4, 16'd3, 16'd2, 16'd1), 1'b0, 1'b0, 0, 0, 1'b0);
    send(pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd4, 16'd3, 16'd2, 16'd1), 1'b0, 1'b0, 0, 0, 1'b0);
    send(pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd4, 16'd3, 16'd2, 16'd1), 1'b1, 1'b1, 30, 30, 1'b1);
    send(pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd4, 16'd3, 16'd2, 16'd1), 1'b1, 1'b1, 10, 10, 1'b1);
    drain();
    send(pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd4, 16'd3, 16'd2, 16'd1), 1'b0, 1'b0, 0, 0, 1'b0);
    send(pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd4, 16'd3, 16'd2, 16'd1), 1'b0, 1'b0, 0, 0, 1'b0);
    pulse_reset_and_check();
    send(pack(16'd1, 16'd1, 16'd1, 16'd1), pack(16'd4, 16'd3, 16'd2, 16'd1), 1'b1, 1'b1, 10, 10, 1'b1);
    drain();
`else
    for (int k = 0; k < 3; k++) begin
      send(pack(16'd4, 16'd3, 16'd2, 16'd1), pack(16'd8, 16'd7, 16'd6, 16'd5), 1'b1, 1'b0, 0, 0, 1'b0);
    end
    pulse_reset_and_check();
`endif
    send(pack(16'd4, 16'd3, 16'd2, 16'd1), pack(16'd8, 16'd7, 16'd6, 16'd5), 1'b1, 1'b1, 70, 70, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    check("sb_empty", OW'(sb[0].size() + sb[1].size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
